// File: rtl/osd_perm_sequencer_if.sv
// Handshake and data bundle between the reliability sorter, the OSD permutation
// sequencer and the systematic-form eliminator.
interface osd_perm_if #(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int IDX_W = $clog2(N)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [K*N-1:0]       gp_flat;
    logic [N*IDX_W-1:0]   lambda1_flat;
    logic                 out_valid;
    logic                 out_ready;
    logic [K*N-1:0]       gpp_flat;
    logic [N*IDX_W-1:0]   lambda_flat;
    logic [N*IDX_W-1:0]   lambda2_flat;
    logic                 rank_err;
    logic                 busy;

    modport master (
        output in_valid, gp_flat, lambda1_flat, out_ready,
        input  in_ready, out_valid, gpp_flat, lambda_flat, lambda2_flat, rank_err, busy
    );

    modport slave (
        input  in_valid, gp_flat, lambda1_flat, out_ready,
        output in_ready, out_valid, gpp_flat, lambda_flat, lambda2_flat, rank_err, busy
    );
endinterface

// File: rtl/osd_perm_sequencer.sv
// OSD reprocessing frame sequencer: holds G' for a settle window around a combinational
// column-pivot generator, captures G''/lambda2 and serially composes lambda1[lambda2[i]].

// Greedy GF(2) pivot search over the columns of G'. Independent columns fill the first K
// slots in column order, the rest follow in order. A missing pivot leaves index 0 in its
// slot, so a rank-deficient G' always yields a repeated index.
module lambda2_generator #(
    parameter int N     = 8,
    parameter int K     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [K*N-1:0]     gp_flat,
    output logic [K*N-1:0]     gpp_flat,
    output logic [N*IDX_W-1:0] lambda2_flat
);
    localparam int CNT_W = IDX_W + 1;

    logic [K-1:0]     col   [N];
    logic [K-1:0]     basis [K];
    logic [K-1:0]     basis_ok;
    logic [K-1:0]     v;
    logic             placed;
    logic [N-1:0]     pivot;
    logic [IDX_W-1:0] slot  [N];
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] q_cnt;

    always_comb begin
        basis_ok = '0;
        pivot    = '0;
        v        = '0;
        placed   = 1'b0;
        p_cnt    = '0;
        q_cnt    = '0;
        gpp_flat = '0;
        for (int b = 0; b < K; b++) basis[b] = '0;
        for (int c = 0; c < N; c++) begin
            slot[c] = '0;
            for (int r = 0; r < K; r++) col[c][r] = gp_flat[r*N + c];
        end
        // XOR basis keyed by leading bit: a column is a pivot if it does not reduce to zero
        for (int c = 0; c < N; c++) begin
            v      = col[c];
            placed = 1'b0;
            for (int b = K - 1; b >= 0; b--) begin
                if (!placed && v[b]) begin
                    if (basis_ok[b]) begin
                        v = v ^ basis[b];
                    end else begin
                        basis[b]    = v;
                        basis_ok[b] = 1'b1;
                        pivot[c]    = 1'b1;
                        placed      = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < N; c++) begin
            if (pivot[c]) begin
                if (p_cnt < CNT_W'(K)) slot[p_cnt[IDX_W-1:0]] = IDX_W'(c);
                p_cnt = p_cnt + CNT_W'(1);
            end else begin
                if (q_cnt < CNT_W'(N - K)) slot[IDX_W'(K) + q_cnt[IDX_W-1:0]] = IDX_W'(c);
                q_cnt = q_cnt + CNT_W'(1);
            end
        end
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < K; r++) gpp_flat[r*N + c] = col[slot[c]][r];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_l2_pack
        assign lambda2_flat[gi*IDX_W +: IDX_W] = slot[gi];
    end
endmodule

module osd_perm_sequencer #(
    parameter int N          = 8,
    parameter int K          = 4,
    parameter int IDX_W      = $clog2(N),
    parameter int SETTLE_CYC = 2
) (
    input logic       clk,
    input logic       rst_n,
    osd_perm_if.slave bus
);
    localparam int CNT_W = IDX_W + 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, COMPOSE, DONE} state_t;

    state_t           state_reg;
    logic [K*N-1:0]   gp_reg;
    logic [K*N-1:0]   gpp_reg;
    logic [IDX_W-1:0] lambda1_reg [N];
    logic [IDX_W-1:0] lambda2_reg [N];
    logic [IDX_W-1:0] lambda_reg  [N];
    logic [N-1:0]     seen_reg;
    logic             err_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [SET_W-1:0] settle_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             rank_err_reg;
    logic             busy_reg;

    logic [K*N-1:0]     gen_gpp;
    logic [N*IDX_W-1:0] gen_l2_flat;
    logic [IDX_W-1:0]   gen_l2     [N];
    logic [IDX_W-1:0]   lambda1_in [N];
    logic [IDX_W-1:0]   cur_idx;
    logic               cur_oob;

    // Fed only from the captured copy, so bus changes mid-frame never reach the generator
    lambda2_generator #(.N(N), .K(K), .IDX_W(IDX_W)) u_gen (
        .gp_flat      (gp_reg),
        .gpp_flat     (gen_gpp),
        .lambda2_flat (gen_l2_flat)
    );

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign gen_l2[gi]     = gen_l2_flat[gi*IDX_W +: IDX_W];
        assign lambda1_in[gi] = bus.lambda1_flat[gi*IDX_W +: IDX_W];
        assign bus.lambda_flat[gi*IDX_W +: IDX_W]  = lambda_reg[gi];
        assign bus.lambda2_flat[gi*IDX_W +: IDX_W] = lambda2_reg[gi];
    end

    assign cur_idx = lambda2_reg[cnt_reg[IDX_W-1:0]];
    assign cur_oob = {1'b0, cur_idx} >= CNT_W'(N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            gp_reg        <= '0;
            gpp_reg       <= '0;
            seen_reg      <= '0;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            settle_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            rank_err_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            for (int i = 0; i < N; i++) begin
                lambda1_reg[i] <= '0;
                lambda2_reg[i] <= '0;
                lambda_reg[i]  <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        gp_reg       <= bus.gp_flat;
                        for (int i = 0; i < N; i++) lambda1_reg[i] <= lambda1_in[i];
                        seen_reg     <= '0;
                        err_reg      <= 1'b0;
                        cnt_reg      <= '0;
                        settle_reg   <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_reg == SET_W'(SETTLE_CYC - 1)) begin
                        state_reg <= CAPTURE;
                    end else begin
                        settle_reg <= settle_reg + SET_W'(1);
                    end
                end
                CAPTURE: begin
                    gpp_reg <= gen_gpp;
                    for (int i = 0; i < N; i++) lambda2_reg[i] <= gen_l2[i];
                    cnt_reg   <= '0;
                    state_reg <= COMPOSE;
                end
                COMPOSE: begin
                    // cnt reaches N before leaving, hence the extra counter bit
                    if (cnt_reg == CNT_W'(N)) begin
                        out_valid_reg <= 1'b1;
                        rank_err_reg  <= err_reg;
                        state_reg     <= DONE;
                    end else begin
                        if (cur_oob) begin
                            lambda_reg[cnt_reg[IDX_W-1:0]] <= '0;
                            err_reg <= 1'b1;
                        end else begin
                            lambda_reg[cnt_reg[IDX_W-1:0]] <= lambda1_reg[cur_idx];
                            err_reg           <= err_reg | seen_reg[cur_idx];
                            seen_reg[cur_idx] <= 1'b1;
                        end
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        rank_err_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.rank_err  = rank_err_reg;
    assign bus.busy      = busy_reg;
    assign bus.gpp_flat  = gpp_reg;
endmodule

// File: tb/tb_osd_perm_sequencer.sv
// Directed and randomized frames for osd_perm_sequencer, checked against a span-set
// model of greedy column selection over GF(2).
module tb_osd_perm_sequencer;
    localparam int N = 8;
    localparam int K = 4;
    localparam int IDX_W = 3;
    localparam int LAT = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    osd_perm_if #(.N(N), .K(K), .IDX_W(IDX_W)) bus ();

    osd_perm_sequencer #(.N(N), .K(K), .IDX_W(IDX_W), .SETTLE_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] pk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        int a [8];
        logic [23:0] r;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7};
        r = '0;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(a[i]);
        return r;
    endfunction

    // Column c joins the pivot list iff it lies outside the span of earlier pivots;
    // the span is tracked as a set of all 16 reachable 4-bit vectors.
    task automatic model(input logic [31:0] g, input logic [23:0] l,
                         output logic [23:0] m_l2, output logic [23:0] m_lam,
                         output logic [31:0] m_gpp, output logic m_err);
        logic [15:0] span, nspan;
        logic [3:0] cv;
        int piv [$];
        int non [$];
        int order [$];
        int src;
        span = 16'h0001;
        for (int c = 0; c < 8; c++) begin
            for (int r = 0; r < 4; r++) cv[r] = g[r*8 + c];
            if (!span[cv]) begin
                piv.push_back(c);
                nspan = span;
                for (int s = 0; s < 16; s++) if (span[s]) nspan[s ^ int'(cv)] = 1'b1;
                span = nspan;
            end else begin
                non.push_back(c);
            end
        end
        m_err = (piv.size() < 4);
        order = {piv, non};
        m_l2 = '0; m_lam = '0; m_gpp = '0;
        for (int i = 0; i < 8; i++) begin
            src = order[i];
            m_l2[i*3 +: 3]  = 3'(src);
            m_lam[i*3 +: 3] = l[src*3 +: 3];
            for (int r = 0; r < 4; r++) m_gpp[r*8 + i] = g[r*8 + src];
        end
    endtask

    task automatic send(input logic [31:0] g, input logic [23:0] l, input bit hold);
        int guard = 0;
        bus.gp_flat = g;
        bus.lambda1_flat = l;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        check("accept_timeout", 64'(guard >= 50), 0);
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        check("in_ready_after_accept", bus.in_ready, 0);
        check("busy_after_accept", bus.busy, 1);
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check("latency", lat, LAT);
    endtask

    task automatic check_frame(input string tag, input logic [31:0] g, input logic [23:0] l);
        logic [23:0] m_l2, m_lam;
        logic [31:0] m_gpp;
        logic m_err;
        model(g, l, m_l2, m_lam, m_gpp, m_err);
        $display("frame %s gp=%08h l1=%06h -> rank_err=%0d lambda2=%06h lambda=%06h gpp=%08h",
                 tag, g, l, bus.rank_err, bus.lambda2_flat, bus.lambda_flat, bus.gpp_flat);
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_rank_err"}, bus.rank_err, m_err);
        if (!m_err) begin
            check({tag, "_lambda2"}, bus.lambda2_flat, m_l2);
            check({tag, "_lambda"}, bus.lambda_flat, m_lam);
            check({tag, "_gpp"}, bus.gpp_flat, m_gpp);
        end
    endtask

    task automatic complete();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_out_valid", bus.out_valid, 0);
        check("post_in_ready", bus.in_ready, 1);
        check("post_busy", bus.busy, 0);
        check("post_rank_err", bus.rank_err, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_rank_err"}, bus.rank_err, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_gpp"}, bus.gpp_flat, 0);
        check({tag, "_lambda"}, bus.lambda_flat, 0);
        check({tag, "_lambda2"}, bus.lambda2_flat, 0);
    endtask

    initial begin
        logic [31:0] g_id, g_dup, g_def, ga, gb, g;
        logic [23:0] l_id, l_rev, la, lb, l;
        logic [23:0] m_l2, m_lam;
        logic [31:0] m_gpp;
        logic m_err;
        int lat, xfers, j, t;
        int perm [8];

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.gp_flat = '0;
        bus.lambda1_flat = '0;
        g_id  = {8'hF8, 8'hF4, 8'hF2, 8'hF1};
        g_dup = {8'h10, 8'h08, 8'h04, 8'h03};
        g_def = {8'h30, 8'h0C, 8'h03, 8'h03};
        l_id  = pk(0, 1, 2, 3, 4, 5, 6, 7);
        l_rev = pk(7, 6, 5, 4, 3, 2, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // identity frame
        send(g_id, l_id, 1'b0);
        wait_done(0, lat);
        check_frame("identity", g_id, l_id);
        check("identity_lambda2_const", bus.lambda2_flat, l_id);
        check("identity_lambda_const", bus.lambda_flat, l_id);
        check("identity_gpp_const", bus.gpp_flat, g_id);
        complete();

        // duplicated column 1, reversed lambda1
        send(g_dup, l_rev, 1'b0);
        wait_done(0, lat);
        check_frame("dupcol", g_dup, l_rev);
        check("dupcol_lambda2_const", bus.lambda2_flat, pk(0, 2, 3, 4, 1, 5, 6, 7));
        check("dupcol_lambda_const", bus.lambda_flat, pk(7, 5, 4, 3, 6, 2, 1, 0));
        check("dupcol_gpp_const", bus.gpp_flat, 32'h08040211);

        // backpressure: outputs frozen for 20 cycles, then exactly one transfer
        model(g_dup, l_rev, m_l2, m_lam, m_gpp, m_err);
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_busy", bus.busy, 1);
            check("bp_lambda", bus.lambda_flat, m_lam);
            check("bp_lambda2", bus.lambda2_flat, m_l2);
            check("bp_gpp", bus.gpp_flat, m_gpp);
        end
        bus.out_ready = 1'b1;
        xfers = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid) xfers++;
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        $display("backpressure release: %0d transfers", xfers);
        check("bp_transfers", xfers, 1);
        check("bp_idle_in_ready", bus.in_ready, 1);
        check("bp_idle_busy", bus.busy, 0);

        // rank-deficient frame, then a clean frame
        send(g_def, l_id, 1'b0);
        wait_done(0, lat);
        check_frame("rankdef", g_def, l_id);
        check("rankdef_err_const", bus.rank_err, 1);
        complete();
        send(g_id, l_rev, 1'b0);
        wait_done(0, lat);
        check_frame("after_rankdef", g_id, l_rev);
        check("after_rankdef_err_const", bus.rank_err, 0);
        complete();

        // reset in COMPOSE with cnt=3
        send(g_dup, l_rev, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(g_dup, l_id, 1'b0);
        wait_done(0, lat);
        check_frame("post_reset", g_dup, l_id);
        complete();

        // bus changes during SETTLE are ignored; held in_valid waits for the IDLE cycle
        ga = 32'h4C_A2_17_E9;
        la = pk(3, 6, 0, 7, 1, 4, 2, 5);
        gb = 32'h81_42_24_18;
        lb = pk(5, 2, 7, 0, 6, 1, 3, 4);
        send(ga, la, 1'b1);
        for (int c = 0; c < 2; c++) begin
            bus.gp_flat = $urandom;
            bus.lambda1_flat = 24'($urandom);
            @(posedge clk); #1;
        end
        bus.gp_flat = gb;
        bus.lambda1_flat = lb;
        wait_done(2, lat);
        check_frame("held_a", ga, la);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("held_idle_in_ready", bus.in_ready, 1);
        check("held_idle_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("held_b_accepted", bus.in_ready, 0);
        wait_done(0, lat);
        check_frame("held_b", gb, lb);
        complete();

        // randomized frames with random downstream delay
        for (int f = 0; f < 16; f++) begin
            g = $urandom;
            for (int i = 0; i < 8; i++) perm[i] = i;
            for (int i = 7; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            l = pk(perm[0], perm[1], perm[2], perm[3], perm[4], perm[5], perm[6], perm[7]);
            send(g, l, 1'b0);
            wait_done(0, lat);
            check_frame("random", g, l);
            repeat ($urandom_range(3, 0)) begin
                @(posedge clk); #1;
                check("random_hold_valid", bus.out_valid, 1);
            end
            complete();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
